// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack for the StackMIPS datapath
// Push/pop/tos strobes from the Controller; registered top-of-stack read, sticky error flags.
module stack_unit #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             tos,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [PTR_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [PTR_W-1:0] count_m1;
   logic [AW-1:0]    top_addr;
   logic             is_empty, is_full;
   logic             set_ovf, set_udf;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == PTR_W'(DEPTH));
   assign count_m1 = count_q - PTR_W'(1);
   assign top_addr = count_m1[AW-1:0];

   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      wr_en   = 1'b0;
      wr_addr = count_q[AW-1:0];
      set_ovf = 1'b0;
      set_udf = 1'b0;

      if (push && pop) begin
         // Replace-top; on an empty stack this degenerates to a plain push.
         wr_en = 1'b1;
         if (is_empty) begin
            wr_addr = '0;
            count_d = PTR_W'(1);
         end else begin
            wr_addr = top_addr;
         end
      end else if (push) begin
         if (is_full) begin
            set_ovf = 1'b1;
         end else begin
            wr_en   = 1'b1;
            count_d = count_q + PTR_W'(1);
         end
      end else if (pop) begin
         if (is_empty) begin
            set_udf = 1'b1;
         end else begin
            count_d = count_m1;
         end
      end

      // tos always sees the pre-edge top, regardless of push/pop in the same cycle.
      if (tos) begin
         if (!is_empty) begin
            dout_d = mem_q[top_addr];
         end else if (!(push && pop)) begin
            set_udf = 1'b1;
         end
      end

      ovf_d = set_ovf | (ovf_q & ~clr_err);
      udf_d = set_udf | (udf_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_addr] <= din;
      end
   end

   assign dout      = dout_q;
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_q;
   assign underflow = udf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - self-checking bench for stack_unit
// Directed Controller-style sequences plus random strobes against a queue-based model.
module tb_stack_unit;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic [PTR_W-1:0] count;
   logic             empty, full, overflow, underflow;

   int tests_run = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0] m_stack [$];
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .clr_err(clr_err),
      .din(din), .dout(dout), .count(count), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic p, input logic o, input logic t,
                             input logic c, input logic [WIDTH-1:0] d);
      bit new_ovf, new_udf;
      int n;
      new_ovf = 0;
      new_udf = 0;
      n = m_stack.size();
      if (r) begin
         m_stack.delete();
         m_dout = '0;
         m_ovf = 0;
         m_udf = 0;
         return;
      end
      if (t) begin
         if (n > 0) m_dout = m_stack[n-1];
         else if (!(p && o)) new_udf = 1;
      end
      if (p && o) begin
         if (n > 0) m_stack[n-1] = d;
         else m_stack.push_back(d);
      end else if (p) begin
         if (n < DEPTH) m_stack.push_back(d);
         else new_ovf = 1;
      end else if (o) begin
         if (n > 0) void'(m_stack.pop_back());
         else new_udf = 1;
      end
      if (c) begin
         m_ovf = 0;
         m_udf = 0;
      end
      if (new_ovf) m_ovf = 1;
      if (new_udf) m_udf = 1;
   endtask

   task automatic step(input logic r, input logic p, input logic o, input logic t,
                       input logic c, input logic [WIDTH-1:0] d);
      rst = r; push = p; pop = o; tos = t; clr_err = c; din = d;
      @(posedge clk);
      #1;
      model_step(r, p, o, t, c, d);
      chk("count", 32'(count), 32'(m_stack.size()));
      chk("dout", 32'(dout), 32'(m_dout));
      chk("empty", 32'(empty), 32'(m_stack.size() == 0));
      chk("full", 32'(full), 32'(m_stack.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      rst = 0; push = 0; pop = 0; tos = 0; clr_err = 0;
   endtask

   initial begin
      // Reset state
      step(1, 0, 0, 0, 0, 8'h00);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);

      // 1: push three, tos
      step(0, 1, 0, 0, 0, 8'h11);
      step(0, 1, 0, 0, 0, 8'h22);
      step(0, 1, 0, 0, 0, 8'h33);
      chk("t1_count", 32'(count), 32'd3);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t1_dout", 32'(dout), 32'h33);

      // 2: pop+tos returns pre-pop top
      step(0, 0, 1, 1, 0, 8'h00);
      chk("t2_dout", 32'(dout), 32'h33);
      chk("t2_count", 32'(count), 32'd2);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t2_dout2", 32'(dout), 32'h22);

      // 3: replace top, then push+pop on empty
      step(0, 1, 1, 0, 0, 8'h7E);
      chk("t3_count", 32'(count), 32'd2);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t3_dout", 32'(dout), 32'h7E);
      step(1, 0, 0, 0, 0, 8'h00);
      step(0, 1, 1, 0, 0, 8'h7E);
      chk("t3e_count", 32'(count), 32'd1);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t3e_dout", 32'(dout), 32'h7E);
      chk("t3e_flags", 32'({overflow, underflow}), 32'd0);

      // 4: fill, overflow, clr_err
      step(1, 0, 0, 0, 0, 8'h00);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0, 8'(i));
      step(0, 1, 0, 0, 0, 8'hAA);
      chk("t4_full", 32'(full), 32'd1);
      chk("t4_ovf", 32'(overflow), 32'd1);
      chk("t4_count", 32'(count), 32'd16);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t4_dout", 32'(dout), 32'h0F);
      step(0, 1, 1, 0, 0, 8'h55);
      chk("t4_rep_ovf_kept", 32'(overflow), 32'd1);
      step(0, 0, 0, 0, 1, 8'h00);
      chk("t4_clr", 32'(overflow), 32'd0);

      // 5: underflow on empty
      step(1, 0, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 0, 8'h44);
      step(0, 0, 0, 1, 0, 8'h00);
      step(0, 0, 1, 0, 0, 8'h00);
      step(0, 0, 1, 0, 0, 8'h00);
      chk("t5_udf", 32'(underflow), 32'd1);
      chk("t5_count", 32'(count), 32'd0);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t5_dout_hold", 32'(dout), 32'h44);
      step(0, 0, 1, 0, 1, 8'h00);
      chk("t5_clr_vs_new", 32'(underflow), 32'd1);
      step(0, 0, 0, 0, 1, 8'h00);
      chk("t5_clr", 32'(underflow), 32'd0);

      // 6: R-type sequence on {5,3}, then reset mid-sequence
      step(1, 0, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 0, 8'd5);
      step(0, 1, 0, 0, 0, 8'd3);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t6_a", 32'(dout), 32'd3);
      step(0, 0, 1, 0, 0, 8'h00);
      step(0, 0, 1, 1, 0, 8'h00);
      chk("t6_b", 32'(dout), 32'd5);
      step(0, 1, 0, 0, 0, 8'd8);
      chk("t6_count", 32'(count), 32'd1);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("t6_top", 32'(dout), 32'd8);
      step(0, 1, 0, 0, 0, 8'd9);
      step(1, 1, 0, 1, 0, 8'd7);
      chk("t6_rst_count", 32'(count), 32'd0);
      chk("t6_rst_dout", 32'(dout), 32'd0);

      // Random strobes against the model
      for (int i = 0; i < 600; i++) begin
         logic r, p, o, t, c;
         r = ($urandom_range(0, 99) == 0);
         p = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 60 : 35));
         o = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 55));
         t = ($urandom_range(0, 99) < 40);
         c = ($urandom_range(0, 99) < 8);
         step(r, p, o, t, c, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
